// File: rtl/output_arbiter.sv
// -----------------------------------------------------------------------------
// output_arbiter
//
// Per-output round-robin arbiter for a flit-switched router. Several input
// ports compete for one downstream FIFO. Once a port wins, the output stays
// locked to it until a whole packet (packet_flits flits) has been written.
// A full downstream FIFO only pauses the packet.
//
// Parameters
//   flit_size    : bits per flit
//   num_ports    : number of requesting input ports
//   packet_flits : flits per packet
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   reset      : asynchronous, active-high reset
//   req        : bit i = port i requests this output
//   flits_in   : port i flit on bits [flit_size*i +: flit_size]
//   dest_full  : downstream FIFO full
//   grant      : registered one-hot grant, all-zero when idle
//   stall      : per-port hold-off back to the input ports
//   flit_out   : flit forwarded downstream (granted port's flit)
//   write_out  : downstream FIFO write enable
//   busy       : high while a packet is locked to a port
// -----------------------------------------------------------------------------
module output_arbiter #(
  parameter int flit_size    = 4,
  parameter int num_ports    = 5,
  parameter int packet_flits = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [num_ports-1:0]           req,
  input  logic [num_ports*flit_size-1:0] flits_in,
  input  logic                           dest_full,
  output logic [num_ports-1:0]           grant,
  output logic [num_ports-1:0]           stall,
  output logic [flit_size-1:0]           flit_out,
  output logic                           write_out,
  output logic                           busy
);

  localparam int IDX_W = (num_ports > 1) ? $clog2(num_ports) : 1;
  localparam int CNT_W = (packet_flits > 1) ? $clog2(packet_flits) : 1;
  localparam logic [CNT_W-1:0] LAST_FLIT    = CNT_W'(packet_flits - 1);
  localparam logic [IDX_W-1:0] LAST_PORT_RST = IDX_W'(num_ports - 1);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [CNT_W-1:0]     flit_cnt;
  logic [IDX_W-1:0]     last_granted;
  logic [IDX_W-1:0]     rr_idx;
  logic [num_ports-1:0] rr_onehot;
  logic [IDX_W-1:0]     grant_idx;
  logic                 xfer_wr;
  logic                 pkt_last_wr;

  // Round-robin search: the port after the last winner has top priority,
  // wrapping from num_ports-1 back to 0. The last winner itself is checked
  // last, so a lone requester can be granted back-to-back.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [num_ports-1:0] r,
    input logic [IDX_W-1:0]     last
  );
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= num_ports; k++) begin
      idx = (int'(last) + k) % num_ports;
      if (!found && r[IDX_W'(idx)]) begin
        found = 1'b1;
        pick  = IDX_W'(idx);
      end
    end
    return pick;
  endfunction

  // Index of the currently granted port (grant is one-hot or zero).
  function automatic logic [IDX_W-1:0] onehot_to_idx(
    input logic [num_ports-1:0] oh
  );
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < num_ports; i++) begin
      if (oh[i]) begin
        idx = idx | IDX_W'(i);
      end
    end
    return idx;
  endfunction

  always_comb begin
    rr_idx = rr_pick(req, last_granted);
    for (int i = 0; i < num_ports; i++) begin
      rr_onehot[i] = (IDX_W'(i) == rr_idx);
    end
  end

  assign grant_idx   = onehot_to_idx(grant);
  assign xfer_wr     = (state == XFER) && !dest_full;
  assign pkt_last_wr = xfer_wr && (flit_cnt == LAST_FLIT);

  // ---- FSM state register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---- FSM next-state logic ----
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (|req) begin
          state_next = XFER;
        end
      end
      XFER: begin
        if (pkt_last_wr) begin
          state_next = IDLE;
        end
      end
    endcase
  end

  // ---- FSM outputs ----
  // Grant is the only selector for flit_out; an all-zero grant yields a zero
  // flit. stall holds back losers and, while the FIFO is full, the winner.
  always_comb begin
    write_out = xfer_wr;
    busy      = (state == XFER);
    stall     = (req & ~grant) | (grant & {num_ports{dest_full}});
    flit_out  = '0;
    for (int i = 0; i < num_ports; i++) begin
      if (grant[i]) begin
        flit_out = flit_out | flits_in[i*flit_size +: flit_size];
      end
    end
  end

  // ---- grant / flit counter / round-robin pointer ----
  // Grant is loaded only from IDLE, so req changes during XFER are ignored.
  // The counter only moves on an actual write, so a full FIFO freezes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant        <= '0;
      flit_cnt     <= '0;
      last_granted <= LAST_PORT_RST;
    end else begin
      case (state)
        IDLE: begin
          flit_cnt <= '0;
          if (|req) begin
            grant <= rr_onehot;
          end
        end
        XFER: begin
          if (pkt_last_wr) begin
            grant        <= '0;
            flit_cnt     <= '0;
            last_granted <= grant_idx;
          end else if (xfer_wr) begin
            flit_cnt <= flit_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_arbiter.sv
// -----------------------------------------------------------------------------
// tb_output_arbiter
//
// Directed bench for output_arbiter with a scoreboard. Each input port is
// modelled as a small upstream source that advances to its next flit when it
// is granted and not stalled. Stimulus pushes the flits that must appear
// downstream; a monitor pops one entry on every write_out and compares the
// forwarded flit and the grant.
// -----------------------------------------------------------------------------
module tb_output_arbiter;

  localparam int FW = 4;
  localparam int NP = 5;
  localparam int PF = 8;

  logic             clk;
  logic             reset;
  logic [NP-1:0]    req;
  logic [NP*FW-1:0] flits_in;
  logic             dest_full;
  logic [NP-1:0]    grant;
  logic [NP-1:0]    stall;
  logic [FW-1:0]    flit_out;
  logic             write_out;
  logic             busy;

  output_arbiter #(
    .flit_size   (FW),
    .num_ports   (NP),
    .packet_flits(PF)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .flits_in (flits_in),
    .dest_full(dest_full),
    .grant    (grant),
    .stall    (stall),
    .flit_out (flit_out),
    .write_out(write_out),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    int            port;
    logic [FW-1:0] data;
  } exp_t;

  exp_t exp_q[$];

  // Flit k of a packet from port p.
  function automatic logic [FW-1:0] fdata(input int p, input int k);
    return FW'(p * 5 + k * 3 + 1);
  endfunction

  // Upstream sources: one read pointer per port.
  logic [2:0] ptr [NP];

  always @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (reset) begin
        ptr[p] <= 3'd0;
      end else if (grant[p] && !stall[p]) begin
        ptr[p] <= ptr[p] + 3'd1;
      end
    end
  end

  always_comb begin
    flits_in = '0;
    for (int p = 0; p < NP; p++) begin
      flits_in[p*FW +: FW] = fdata(p, int'(ptr[p]));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: event never arrived within cycle budget (t=%0t)", name, $time);
  endtask

  task automatic push_pkt(input int p, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.port = p;
      e.data = fdata(p, k);
      exp_q.push_back(e);
    end
  endtask

  // Scoreboard monitor: every downstream write must match the next entry.
  always @(negedge clk) begin
    exp_t e;
    if (write_out) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_write: got flit %0h grant %b, required no write (t=%0t)",
                 flit_out, grant, $time);
      end else begin
        e = exp_q.pop_front();
        chk("wr_flit", 32'(flit_out), 32'(e.data));
        chk("wr_grant", 32'(grant), 32'(1) << e.port);
      end
    end
  end

  // Called at a negedge; returns at the first negedge with busy high.
  task automatic wait_busy(output int idle);
    idle = 0;
    while (!busy) begin
      idle++;
      if (idle > 30) begin
        fail_timeout("wait_busy");
        return;
      end
      @(negedge clk);
    end
  endtask

  // Called at a negedge inside a packet; returns at the first idle negedge.
  task automatic run_pkt(input logic [NP-1:0] eg, output int writes,
                         output int cycles, output int bad);
    writes = 0;
    cycles = 0;
    bad    = 0;
    while (busy) begin
      if (write_out) writes++;
      if (grant !== eg) bad++;
      cycles++;
      if (cycles > 60) begin
        fail_timeout("run_pkt");
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int idle, writes, cycles, bad, total;
    logic [NP-1:0] order [6];
    order[0] = 5'b00001; order[1] = 5'b00010; order[2] = 5'b00100;
    order[3] = 5'b01000; order[4] = 5'b10000; order[5] = 5'b00001;

    // Reset state
    reset     = 1'b1;
    req       = 5'b00101;
    dest_full = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_write", 32'(write_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flit", 32'(flit_out), 0);
    chk("rst_stall", 32'(stall), 32'h05);

    // Single requester, port 0: latency, 8 back-to-back writes, idle after
    push_pkt(0, PF);
    #1 reset = 1'b0; req = 5'b00001;
    #1 chk("idle_stall_eq_req", 32'(stall), 32'h01);
    chk("idle_grant_zero", 32'(grant), 0);
    @(negedge clk);
    chk("lat_grant", 32'(grant), 32'h01);
    chk("lat_write", 32'(write_out), 1);
    chk("lat_busy", 32'(busy), 1);
    #1 req = 5'b00000;
    run_pkt(5'b00001, writes, cycles, bad);
    chk("p0_writes", 32'(writes), PF);
    chk("p0_cycles", 32'(cycles), PF);
    chk("p0_grant_held", 32'(bad), 0);
    chk("p0_end_grant", 32'(grant), 0);
    @(negedge clk);
    chk("idle_stays", 32'(busy), 0);

    // Reset again so port 0 has top priority, then all ports request
    #1 reset = 1'b1;
    #1 chk("rst2_grant", 32'(grant), 0);
    @(negedge clk);
    for (int j = 0; j < 6; j++) begin
      for (int p = 0; p < NP; p++) begin
        if (order[j][p]) push_pkt(p, PF);
      end
    end
    #1 reset = 1'b0; req = 5'b11111;
    @(negedge clk);
    for (int j = 0; j < 6; j++) begin
      wait_busy(idle);
      if (j > 0) chk("rr_one_idle", 32'(idle), 1);
      chk("rr_grant", 32'(grant), 32'(order[j]));
      chk("rr_stall", 32'(stall), 32'(5'b11111 & ~order[j]));
      if (j == 5) begin
        #1 req = 5'b00000;
      end
      run_pkt(order[j], writes, cycles, bad);
      chk("rr_writes", 32'(writes), PF);
      chk("rr_grant_held", 32'(bad), 0);
      chk("rr_end_grant", 32'(grant), 0);
    end

    // Port 2 with downstream full for 3 cycles after flit 4
    push_pkt(2, PF);
    #1 req = 5'b00100;
    @(negedge clk);
    wait_busy(idle);
    chk("p2_grant", 32'(grant), 32'h04);
    #1 req = 5'b00000;
    writes = 0;
    cycles = 0;
    while (writes < 4) begin
      if (write_out) writes++;
      if (writes == 4) break;
      cycles++;
      if (cycles > 20) begin
        fail_timeout("p2_first4");
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 dest_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("full_write", 32'(write_out), 0);
      chk("full_stall", 32'(stall), 32'h04);
      chk("full_grant", 32'(grant), 32'h04);
    end
    @(posedge clk);
    #1 dest_full = 1'b0;
    @(negedge clk);
    run_pkt(5'b00100, writes, cycles, bad);
    chk("p2_rest_writes", 32'(writes), 4);
    chk("p2_grant_held", 32'(bad), 0);

    // Port 3, request withdrawn after flit 1
    push_pkt(3, PF);
    #1 req = 5'b01000;
    @(negedge clk);
    wait_busy(idle);
    chk("p3_grant", 32'(grant), 32'h08);
    chk("p3_first_write", 32'(write_out), 1);
    @(posedge clk);
    #1 req = 5'b00000;
    @(negedge clk);
    run_pkt(5'b01000, writes, cycles, bad);
    total = writes + 1;
    chk("p3_writes", 32'(total), PF);
    chk("p3_grant_held", 32'(bad), 0);

    // Port 1, reset after flit 5, then ports 0 and 1 request
    push_pkt(1, 5);
    #1 req = 5'b00010;
    @(negedge clk);
    wait_busy(idle);
    chk("p1_grant", 32'(grant), 32'h02);
    writes = 0;
    cycles = 0;
    while (writes < 5) begin
      if (write_out) writes++;
      if (writes == 5) break;
      cycles++;
      if (cycles > 20) begin
        fail_timeout("p1_first5");
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 reset = 1'b1; req = 5'b00011;
    #1 chk("arst_grant", 32'(grant), 0);
    chk("arst_write", 32'(write_out), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_flit", 32'(flit_out), 0);
    chk("arst_stall", 32'(stall), 32'h03);
    @(negedge clk);
    @(negedge clk);
    chk("arst_hold_write", 32'(write_out), 0);
    push_pkt(0, PF);
    #1 reset = 1'b0;
    @(negedge clk);
    wait_busy(idle);
    chk("post_rst_grant", 32'(grant), 32'h01);
    #1 req = 5'b00000;
    run_pkt(5'b00001, writes, cycles, bad);
    chk("post_rst_writes", 32'(writes), PF);

    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/output_arbiter.md
OUTPUT_ARBITER -- requirements
Module: output_arbiter

Interface
REQ-001 SHALL have parameter flit_size, default 4, meaning bits per flit.
REQ-002 SHALL have parameter num_ports, default 5, meaning number of requesting input ports.
REQ-003 SHALL have parameter packet_flits, default 8, meaning flits per packet (32-bit packet / 4-bit flit).
REQ-004 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req  input  num_ports  bit i is port i's request for this output.
REQ-007 SHALL have port flits_in  input  num_ports*flit_size  port i flit on bits [4i+3:4i].
REQ-008 SHALL have port dest_full  input  1  downstream FIFO full.
REQ-009 SHALL have port grant  output  num_ports  one-hot registered grant, all-zero when idle.
REQ-010 SHALL have port stall  output  num_ports  per-port hold-off to input ports.
REQ-011 SHALL have port flit_out  output  flit_size  flit forwarded downstream.
REQ-012 SHALL have port write_out  output  1  downstream FIFO write enable.
REQ-013 SHALL have port busy  output  1  high while a packet is locked to a port.

Function
REQ-014 SHALL implement a two-state FSM: IDLE, XFER.
REQ-015 In IDLE with req nonzero, SHALL select one port by round-robin, load grant one-hot, clear flit counter, enter XFER on the next edge.
REQ-016 Round-robin priority SHALL start at (last_granted+1) mod num_ports and wrap at num_ports-1 -> 0.
REQ-017 In IDLE with req zero, SHALL remain in IDLE, grant all-zero.
REQ-018 In XFER, write_out SHALL equal !dest_full (combinational).
REQ-019 flit_out SHALL equal the granted port's flits_in slice combinationally; all-zero when grant is zero.
REQ-020 Flit counter (width clog2(packet_flits)) SHALL increment only on cycles with write_out=1.
REQ-021 On a write with counter = packet_flits-1, SHALL clear grant, store granted index as last_granted, return to IDLE.
REQ-022 Grant SHALL be locked for the whole packet; deassertion or change of req during XFER SHALL be ignored.
REQ-023 dest_full during XFER SHALL freeze counter and grant; no flit lost or duplicated.
REQ-024 stall[i] SHALL be 1 when req[i]=1 and grant[i]=0, or grant[i]=1 and dest_full=1; otherwise 0.
REQ-025 In IDLE, stall SHALL equal req (no port advances before grant).
REQ-026 Latency: req seen at edge N -> grant and first possible write_out in cycle N+1.
REQ-027 Packet end SHALL be followed by exactly one IDLE cycle before the next grant.
REQ-028 busy SHALL be 1 exactly when state is XFER.

Reset
REQ-029 Reset SHALL asynchronously force state IDLE, grant 0, counter 0, last_granted num_ports-1 (port 0 highest priority after reset).
REQ-030 During reset, write_out 0, flit_out 0, busy 0, stall equal to req.
REQ-031 Reset mid-packet SHALL abandon the packet; no further write_out until a new grant.

Verification
REQ-032 Reset, req=00001, dest_full=0 -> grant=00001 next cycle, 8 consecutive write_out pulses, then grant=0 for one cycle.
REQ-033 req=11111 held -> grant order 00001,00010,00100,01000,10000,00001, one packet (8 flits) each.
REQ-034 Port 2 granted, dest_full=1 for 3 cycles after flit 4 -> write_out low 3 cycles, stall[2]=1, total exactly 8 writes, flit order preserved.
REQ-035 Port 3 granted, req[3] drops after flit 1 -> grant held, 8 writes completed.
REQ-036 Reset asserted after flit 5 of port 1 -> grant=0, write_out=0 immediately; after release with req=00011 -> port 0 granted first.
